// File: rtl/uart_frame_tx.sv
// Serialises one {col,row,char} screen-write command as a 4-byte 8N1 UART frame
// (col, row, char, terminator), LSB first, with its own baud divider.
module uart_frame_tx #(
    parameter int unsigned CLK_FREQ  = 25000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [6:0] col_i,
    input  logic [4:0] row_i,
    input  logic [6:0] char_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [1:0]      byte_idx, byte_idx_n;
    logic [3:0][7:0] frame, frame_n;
    logic            tx_n, ready_n, busy_n, done_n;
    logic            wrap;

    assign wrap = (cnt == CNT_MAX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            frame        <= '0;
            tx_o         <= 1'b1;
            ready_o      <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            byte_idx     <= byte_idx_n;
            frame        <= frame_n;
            tx_o         <= tx_n;
            ready_o      <= ready_n;
            busy_o       <= busy_n;
            frame_done_o <= done_n;
        end
    end

    // Outputs are computed one cycle early so every output leaves a flop.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        frame_n    = frame;
        tx_n       = tx_o;
        ready_n    = ready_o;
        busy_n     = busy_o;
        done_n     = 1'b0;

        if (state != IDLE)
            cnt_n = wrap ? '0 : cnt + CW'(1);

        case (state)
            IDLE: begin
                if (valid_i && ready_o) begin
                    frame_n    = {TERM_CHAR, {1'b0, char_i}, {3'b000, row_i}, {1'b0, col_i}};
                    state_n    = START;
                    cnt_n      = '0;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                    tx_n       = 1'b0;
                    ready_n    = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            START: begin
                if (wrap) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = frame[byte_idx][0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = frame[byte_idx][bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (wrap) begin
                    // Next byte's start bit follows the stop bit with no idle gap.
                    if (byte_idx == 2'd3) begin
                        state_n = IDLE;
                        ready_n = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        byte_idx_n = byte_idx + 2'd1;
                        state_n    = START;
                        tx_n       = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Transmit side of the screen-write UART protocol. The receive side accepts 4-byte frames in the order column -> row -> char -> line terminator.
- This block accepts one {col,row,char} write command through a valid/ready handshake. It then serialises the full 4-byte frame as 8N1 UART on tx_o, LSB first.
- Used to echo screen writes back to the host, and to drive the display loopback bench.
- Self-contained: it has its own baud divider, bit FSM and byte sequencer.

Parameters:
- CLK_FREQ, 25000000, clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s. Bit period DIV = CLK_FREQ/BAUD_RATE, integer truncated (217 at defaults). DIV must be >= 2.
- TERM_CHAR, 8'h0A, fourth (terminator) byte of every frame.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  command valid.
- ready_o  out  1  block can accept a command.
- col_i  in  7  tile column.
- row_i  in  5  tile row.
- char_i  in  7  ASCII code.
- tx_o  out  1  UART serial output, idle high.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset values (asynchronous, take effect immediately): tx_o=1, ready_o=1, busy_o=0, frame_done_o=0. FSM=IDLE, byte index=0, baud counter=0, bit index=0.
- Reset mid-frame abandons the frame: tx_o returns high at once. No frame_done_o pulse is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- Accept: on a clk_i edge with valid_i=1 and ready_o=1, the block latches the command and leaves IDLE.
  - byte0={1'b0,col_i}
  - byte1={3'b0,row_i}
  - byte2={1'b0,char_i}
  - byte3=TERM_CHAR
- After accept: ready_o=0 and busy_o=1 from the next cycle. valid_i and the command inputs are ignored while busy.
- Column values 80..127 are sent unmodified. Folding them is the receiver's job.
- FSM states: IDLE -> START -> DATA -> STOP -> (START of next byte | IDLE).
- Timing: each bit is held for exactly DIV cycles, counted by a baud counter from 0 to DIV-1. tx_o changes only when the counter wraps.
  - START: tx_o=0.
  - DATA: tx_o=byte[bit_idx], bit_idx 0..7, LSB first.
  - STOP: tx_o=1.
- Bytes are sent back to back: byte k's stop bit is followed directly by byte k+1's start bit, with no extra idle.
- Byte index 0..3. After byte3's STOP completes, the FSM returns to IDLE.
- Latency: tx_o goes low on the first cycle after the accept edge. A frame occupies exactly 40*DIV cycles from that cycle.
- End of frame: in the first IDLE cycle after the frame, ready_o=1, busy_o=0 and frame_done_o=1 for exactly one cycle.
- Back-to-back commands: if valid_i is already high in that cycle, the next command is accepted on that edge. The line then shows exactly one extra high cycle beyond the stop bit before the next start bit.
- Minimum frame-to-frame period is 40*DIV+1 cycles.
- Simultaneous reset and valid_i: reset wins and the command is not accepted.
- No FIFO. Back-pressure is provided only by ready_o.

Test Plan:
- Reset idle check. Use CLK_FREQ=1000, BAUD_RATE=100 (DIV=10). Assert rst_i, release it, hold valid_i=0 for 100 cycles -> tx_o=1, ready_o=1, busy_o=0, frame_done_o=0 throughout.
- Single frame with DIV=10. Send col=5, row=3, char=0x41 ('A').
  - tx_o low at accept+1.
  - Decoded bytes are 0x05, 0x03, 0x41, 0x0A, each with a 10-cycle start bit and a 10-cycle stop bit.
  - busy_o stays high 400 cycles, then frame_done_o pulses once.
- Boundary values. Send col=79, row=29, char=0x7F, then col=127, row=31 -> bytes 0x4F, 0x1D, 0x7F, 0x0A, then 0x7F, 0x1F, ..., 0x0A. No field truncation beyond the stated widths.
- Back-to-back with valid_i held high and two commands queued by the bench.
  - Second start bit begins exactly 401 cycles after the first start bit.
  - ready_o is high for one cycle between the frames.
  - Changing the inputs while busy does not alter byte content.
- Reset mid-frame. Assert rst_i during the DATA bits of byte1 -> tx_o=1 immediately (before the next clk_i edge), ready_o=1, no frame_done_o pulse. The next command produces a complete, correct frame.
- Default parameters (25 MHz, 115200 baud, DIV=217). Send col=10, row=2, char=0x30 -> a UART monitor sampling at bit centres (108 cycles into each bit) decodes 0x0A, 0x02, 0x30, 0x0A. Total frame is 8680 cycles.
